pcie_tx: RTL and testbench

PCIE_TX -- requirements
Module: pcie_tx

---
 rtl/pcie_tx_pkg.sv | 22 ++
 rtl/pcie_tx_cmdq.sv | 63 ++++++
 rtl/pcie_tx.sv | 124 ++++++++++++
 tb/tb_pcie_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the PCIe-style transmit block: FSM encoding,
// outgoing word layout and the command length decoding rule.
package pcie_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int DO_VC      = 5;
  localparam int DO_DEST    = 4;
  localparam int DO_SEQ_LSB = 0;
  localparam int SEQ_W      = 4;
  localparam int NUM_FLOWS  = 4;

  // A zero length field stands for a full 16-word packet.
  function automatic logic [8:0] len_words(input logic [7:0] len);
    if (len == 8'd0) return 9'd16;
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/pcie_tx_cmdq.sv
// Command queue: circular buffer with read/write pointers and an occupancy
// count that stays correct when a push and a pop land in the same cycle.
module pcie_tx_cmdq #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         i_init,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_push && !i_init) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_init) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= next_ptr(r_wr);
      if (w_pop)  r_rd <= next_ptr(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pcie_tx.sv
// Transmit engine: queues packet commands and streams each packet as words
// tagged with vc, dest and a per-flow sequence number, stalling on pause.
module pcie_tx
  import pcie_tx_pkg::*;
#(
  parameter int WORD_SIZE = 6,
  parameter int CMD_DEPTH = 4,
  parameter int LEN_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_vc,
  input  logic                 cmd_dest,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 pause,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 push_out,
  output logic                 idle,
  output logic [7:0]           words_sent
);

  localparam int QW = LEN_W + 2;

  state_t           r_state;
  logic             r_vc;
  logic             r_dest;
  logic [8:0]       r_remain;
  logic [SEQ_W-1:0] r_seq [NUM_FLOWS];
  logic [7:0]       r_words;

  logic             w_q_full;
  logic             w_q_empty;
  logic [QW-1:0]    w_q_dout;
  logic             w_accept;
  logic             w_push;
  logic             w_last;
  logic             w_pop;
  logic [1:0]       w_flow;
  logic [WORD_SIZE-1:0] w_word;

  assign cmd_ready  = !w_q_full;
  assign w_accept   = cmd_valid && !w_q_full && !init;
  assign w_push     = (r_state == ST_SEND) && !pause;
  assign w_last     = w_push && (r_remain == 9'd1);
  assign w_pop      = !init && !w_q_empty && ((r_state == ST_IDLE) || w_last);
  assign w_flow     = {r_vc, r_dest};
  assign push_out   = w_push;
  assign idle       = (r_state == ST_IDLE) && w_q_empty;
  assign words_sent = r_words;
  assign data_out   = w_word;

  pcie_tx_cmdq #(.DEPTH(CMD_DEPTH), .W(QW)) u_cmdq (
    .clk     (clk),
    .reset_L (reset_L),
    .i_init  (init),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_din   ({cmd_vc, cmd_dest, cmd_len}),
    .o_dout  (w_q_dout),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  // The word is held (not advanced) while paused, so nothing is skipped.
  always_comb begin
    w_word = '0;
    if (r_state == ST_SEND) begin
      w_word[DO_VC]                   = r_vc;
      w_word[DO_DEST]                 = r_dest;
      w_word[DO_SEQ_LSB +: SEQ_W]     = r_seq[w_flow];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= ST_IDLE;
      r_vc     <= 1'b0;
      r_dest   <= 1'b0;
      r_remain <= '0;
      r_words  <= '0;
      for (int i = 0; i < NUM_FLOWS; i++) r_seq[i] <= '0;
    end else if (init) begin
      r_state  <= ST_IDLE;
      r_vc     <= 1'b0;
      r_dest   <= 1'b0;
      r_remain <= '0;
      r_words  <= '0;
      for (int i = 0; i < NUM_FLOWS; i++) r_seq[i] <= '0;
    end else begin
      if (w_push) begin
        r_seq[w_flow] <= r_seq[w_flow] + 1'b1;
        r_words       <= r_words + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_q_empty) begin
            r_state  <= ST_SEND;
            r_vc     <= w_q_dout[LEN_W+1];
            r_dest   <= w_q_dout[LEN_W];
            r_remain <= len_words(8'(w_q_dout[LEN_W-1:0]));
          end
        end
        ST_SEND: begin
          if (w_last) begin
            if (!w_q_empty) begin
              r_vc     <= w_q_dout[LEN_W+1];
              r_dest   <= w_q_dout[LEN_W];
              r_remain <= len_words(8'(w_q_dout[LEN_W-1:0]));
            end else begin
              r_state  <= ST_IDLE;
            end
          end else if (w_push) begin
            r_remain <= r_remain - 9'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx.sv
// Directed bench for pcie_tx: a cycle table for single, paused and
// back-to-back packets, then hand sequences for the multi-cycle corners.
module tb_pcie_tx;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_vc;
  logic       cmd_dest;
  logic [3:0] cmd_len;
  logic       pause;
  logic [5:0] data_out;
  logic       push_out;
  logic       idle;
  logic [7:0] words_sent;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcie_tx #(.WORD_SIZE(6), .CMD_DEPTH(4), .LEN_W(4)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .init       (init),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_vc     (cmd_vc),
    .cmd_dest   (cmd_dest),
    .cmd_len    (cmd_len),
    .pause      (pause),
    .data_out   (data_out),
    .push_out   (push_out),
    .idle       (idle),
    .words_sent (words_sent)
  );

  typedef struct {
    logic       init;
    logic       v;
    logic       vc;
    logic       dest;
    logic [3:0] len;
    logic       pause;
    logic       ready;
    logic       push;
    logic [5:0] data;
    logic       idl;
    logic [7:0] ws;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic i_init, input logic v, input logic vc, input logic dest,
                     input logic [3:0] len, input logic p, input logic rdy, input logic psh,
                     input logic [5:0] d, input logic idl, input logic [7:0] ws);
    vec_t t;
    t.init = i_init; t.v = v; t.vc = vc; t.dest = dest; t.len = len; t.pause = p;
    t.ready = rdy; t.push = psh; t.data = d; t.idl = idl; t.ws = ws;
    vecs.push_back(t);
  endtask

  task automatic set_in(input logic i_init, input logic v, input logic vc, input logic dest,
                        input logic [3:0] len, input logic p);
    init = i_init; cmd_valid = v; cmd_vc = vc; cmd_dest = dest; cmd_len = len; pause = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    set_in(1, 0, 0, 0, 0, 0);
    step();
    init = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (!idle && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(idle), 32'(1));
    step();
  endtask

  initial begin
    int accepted;
    reset_L = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst.push", 32'(push_out), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.ready", 32'(cmd_ready), 1);
    chk("rst.idle", 32'(idle), 1);
    chk("rst.ws", 32'(words_sent), 0);
    @(negedge clk);
    reset_L = 1'b1;
    step();

    // single packet vc1 dest0 len3
    add(0,1,1,0,3,0, 1,0,6'h00,1,0);
    add(0,0,0,0,0,0, 1,0,6'h00,0,0);
    add(0,0,0,0,0,0, 1,1,6'h20,0,0);
    add(0,0,0,0,0,0, 1,1,6'h21,0,1);
    add(0,0,0,0,0,0, 1,1,6'h22,0,2);
    add(0,0,0,0,0,0, 1,0,6'h00,1,3);
    add(1,0,0,0,0,0, 1,0,6'h00,1,3);
    // same packet with pause in cycles 3-4
    add(0,1,1,0,3,0, 1,0,6'h00,1,0);
    add(0,0,0,0,0,0, 1,0,6'h00,0,0);
    add(0,0,0,0,0,0, 1,1,6'h20,0,0);
    add(0,0,0,0,0,1, 1,0,6'h21,0,1);
    add(0,0,0,0,0,1, 1,0,6'h21,0,1);
    add(0,0,0,0,0,0, 1,1,6'h21,0,1);
    add(0,0,0,0,0,0, 1,1,6'h22,0,2);
    add(0,0,0,0,0,0, 1,0,6'h00,1,3);
    add(1,0,0,0,0,0, 1,0,6'h00,1,3);
    // two back-to-back packets vc0 dest1 len2
    add(0,1,0,1,2,0, 1,0,6'h00,1,0);
    add(0,1,0,1,2,0, 1,0,6'h00,0,0);
    add(0,0,0,0,0,0, 1,1,6'h10,0,0);
    add(0,0,0,0,0,0, 1,1,6'h11,0,1);
    add(0,0,0,0,0,0, 1,1,6'h12,0,2);
    add(0,0,0,0,0,0, 1,1,6'h13,0,3);
    add(0,0,0,0,0,0, 1,0,6'h00,1,4);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].init, vecs[i].v, vecs[i].vc, vecs[i].dest, vecs[i].len, vecs[i].pause);
      @(negedge clk);
      chk($sformatf("row%0d.ready", i), 32'(cmd_ready), 32'(vecs[i].ready));
      chk($sformatf("row%0d.push", i), 32'(push_out), 32'(vecs[i].push));
      chk($sformatf("row%0d.data", i), 32'(data_out), 32'(vecs[i].data));
      chk($sformatf("row%0d.idle", i), 32'(idle), 32'(vecs[i].idl));
      chk($sformatf("row%0d.ws", i), 32'(words_sent), 32'(vecs[i].ws));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);

    // len=0 (16 words) then len=1 on flow (1,1): sequence wraps to 0
    do_init();
    set_in(0, 1, 1, 1, 0, 0); step();
    set_in(0, 1, 1, 1, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("wrap.push%0d", i), 32'(push_out), 1);
      chk($sformatf("wrap.data%0d", i), 32'(data_out), 32'(8'h30 | (i % 16)));
      step();
    end
    @(negedge clk);
    chk("wrap.idle", 32'(idle), 1);
    chk("wrap.ws", 32'(words_sent), 17);
    step();

    // queue fills under pause: 1 in flight + 4 queued
    do_init();
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      set_in(0, 1, 0, 0, 1, 1);
      @(negedge clk);
      if (cmd_ready) accepted++;
      if (c >= 5) chk($sformatf("full.ready_c%0d", c), 32'(cmd_ready), 0);
      if (c == 3) chk("full.push_paused", 32'(push_out), 0);
      step();
    end
    chk("full.accepted", 32'(accepted), 5);
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full.drop.push", 32'(push_out), 1);
    chk("full.drop.data", 32'(data_out), 6'h00);
    chk("full.drop.ready", 32'(cmd_ready), 0);
    step();
    @(negedge clk);
    chk("full.after.ready", 32'(cmd_ready), 1);
    chk("full.after.push", 32'(push_out), 1);
    chk("full.after.data", 32'(data_out), 6'h01);
    step();
    wait_idle("full.drain_timeout", 20);
    @(negedge clk);
    chk("full.ws", 32'(words_sent), 5);
    step();

    // asynchronous reset mid-packet
    do_init();
    set_in(0, 1, 1, 1, 5, 0); step();
    set_in(0, 0, 0, 0, 0, 0); step();
    step();
    @(negedge clk);
    chk("rstmid.push_before", 32'(push_out), 1);
    chk("rstmid.data_before", 32'(data_out), 6'h31);
    #2 reset_L = 1'b0;
    #1;
    chk("rstmid.push", 32'(push_out), 0);
    chk("rstmid.data", 32'(data_out), 0);
    chk("rstmid.idle", 32'(idle), 1);
    chk("rstmid.ready", 32'(cmd_ready), 1);
    chk("rstmid.ws", 32'(words_sent), 0);
    step();
    reset_L = 1'b1;
    step();
    @(negedge clk);
    chk("rstmid.no_retain", 32'(idle), 1);
    step();
    set_in(0, 1, 1, 1, 2, 0); step();
    set_in(0, 0, 0, 0, 0, 0); step();
    @(negedge clk);
    chk("rstmid.restart_push", 32'(push_out), 1);
    chk("rstmid.restart_data", 32'(data_out), 6'h30);
    step();
    wait_idle("rstmid.drain_timeout", 10);

    // synchronous init mid-packet
    do_init();
    set_in(0, 1, 0, 0, 5, 0); step();
    set_in(0, 0, 0, 0, 0, 0); step();
    step();
    step();
    init = 1'b1;
    @(negedge clk);
    chk("initmid.push_same", 32'(push_out), 1);
    chk("initmid.data_same", 32'(data_out), 6'h02);
    step();
    init = 1'b0;
    @(negedge clk);
    chk("initmid.push_next", 32'(push_out), 0);
    chk("initmid.idle", 32'(idle), 1);
    chk("initmid.data", 32'(data_out), 0);
    chk("initmid.ws", 32'(words_sent), 0);
    step();
    set_in(0, 1, 0, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0); step();
    @(negedge clk);
    chk("initmid.restart_push", 32'(push_out), 1);
    chk("initmid.restart_data", 32'(data_out), 6'h00);
    step();
    @(negedge clk);
    chk("initmid.final_idle", 32'(idle), 1);
    chk("initmid.final_ws", 32'(words_sent), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
